// File: rtl/rh_latch_pkg.sv
// Shared definitions for the rh_latch NAND-latch model: state encoding,
// output decode constants, default parameters and small helper functions.
package rh_latch_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    CLR    = 2'b00,
    SET    = 2'b01,
    FORBID = 2'b10
  } rh_state_e;

  // Packed as {q, p}
  typedef struct packed {
    logic q;
    logic p;
  } rh_out_t;

  localparam rh_out_t OUT_CLR    = 2'b01;
  localparam rh_out_t OUT_SET    = 2'b10;
  localparam rh_out_t OUT_FORBID = 2'b11;

  function automatic rh_out_t decode(input rh_state_e s);
    rh_out_t o;
    case (s)
      SET:     o = OUT_SET;
      FORBID:  o = OUT_FORBID;
      default: o = OUT_CLR;
    endcase
    return o;
  endfunction

  // Next state from the filtered active-low inputs. Leaving FORBID with both
  // inputs released at once resolves to CLR so the outcome is deterministic.
  function automatic rh_state_e next_state(input rh_state_e s, input logic r, input logic h);
    rh_state_e n;
    case ({r, h})
      2'b11:   n = (s == FORBID) ? CLR : s;
      2'b01:   n = CLR;
      2'b10:   n = SET;
      default: n = FORBID;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rh_sync.sv
// Input conditioner: SYNC_STAGES-deep synchronizer followed by a stability
// filter that accepts a new level only after FILTER_CYCLES consecutive equal
// synchronized samples. All flops reset to 1 (input inactive).
module rh_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o
);

  localparam int            CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   filt_q;
  logic                   filt_d;
  logic [CW-1:0]          cnt_q;
  logic                   differ;
  logic                   accept;

  // Synchronizer shift chain; stage 0 samples the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign differ = (sync_s != filt_q);
  // Down-counter reaching zero while the sample still differs means the
  // sample has now been seen FILTER_CYCLES times in a row.
  assign accept = differ && (cnt_q == '0);
  assign filt_d = accept ? sync_s : filt_q;
  assign level_o = filt_d;

  // Stability filter: reload the down-counter whenever the sample agrees
  // with the accepted level, count down while it disagrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      cnt_q  <= CNT_LOAD;
    end else if (!differ || accept) begin
      filt_q <= filt_d;
      cnt_q  <= CNT_LOAD;
    end else begin
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/rh_latch.sv
// Clocked model of a cross-coupled NAND latch with active-low R (clear) and
// H (set) inputs. Q and P are registered decodes of the latch state.
// Optional sticky illegal-input flag: define RH_LATCH_ILLEGAL_FLAG_EN to add
// the err output.
//
//   state  | meaning
//   CLR    | latch cleared, Q=0 P=1
//   SET    | latch set,     Q=1 P=0
//   FORBID | both inputs active, both NAND outputs forced high, Q=1 P=1
module rh_latch
  import rh_latch_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic R,
  input  logic H,
  output logic P,
  output logic Q
`ifdef RH_LATCH_ILLEGAL_FLAG_EN
  ,
  output logic err
`endif
);

  logic      r_f;
  logic      h_f;
  rh_state_e state_q;
  rh_state_e state_d;
  rh_out_t   out_q;

  rh_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync_r (
    .clk    (clk),
    .rst    (rst),
    .async_i(R),
    .level_o(r_f)
  );

  rh_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync_h (
    .clk    (clk),
    .rst    (rst),
    .async_i(H),
    .level_o(h_f)
  );

  // Next-state decode from the filtered input pair.
  always_comb begin
    state_d = next_state(state_q, r_f, h_f);
  end

  // State register with outputs decoded from the next state so Q/P change
  // on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR;
      out_q   <= OUT_CLR;
    end else begin
      state_q <= state_d;
      out_q   <= decode(state_d);
    end
  end

  assign Q = out_q.q;
  assign P = out_q.p;

`ifdef RH_LATCH_ILLEGAL_FLAG_EN
  logic err_q;

  // Sticky flag set on entry into FORBID, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_d == FORBID) && (state_q != FORBID)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_rh_latch.sv
// Self-checking bench for rh_latch: table-driven vectors with a cycle-stamped
// scoreboard on the default instance, plus hand-written sequences for the
// glitch filter (FILTER_CYCLES=4 instance) and asynchronous reset.
module tb_rh_latch;

`ifdef RH_LATCH_ILLEGAL_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic r1, h1, r2, h2;
  logic q1, p1, q2, p2;
  logic err1, err2;

  always #5 clk = ~clk;

  rh_latch dut1 (
    .clk(clk),
    .rst(rst),
    .R  (r1),
    .H  (h1),
    .P  (p1),
    .Q  (q1)
`ifdef RH_LATCH_ILLEGAL_FLAG_EN
    ,
    .err(err1)
`endif
  );

  rh_latch #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .R  (r2),
    .H  (h2),
    .P  (p2),
    .Q  (q2)
`ifdef RH_LATCH_ILLEGAL_FLAG_EN
    ,
    .err(err2)
`endif
  );

`ifndef RH_LATCH_ILLEGAL_FLAG_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected observation packed as {Q, P, err}
  function automatic logic [2:0] mk(input logic q, input logic p, input logic e);
    return {q, p, e & ERR_EN};
  endfunction

  function automatic void chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {Q,P,err}=%b expected %b", nm, act, exp);
    end
  endfunction

  typedef struct {
    int         due;
    logic [2:0] exp;
    string      nm;
  } sb_t;

  typedef struct {
    logic       r;
    logic       h;
    int         hold;
    logic [2:0] exp;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[14];

  // Monitor: counts rising edges and compares scoreboard entries due now.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due == cyc) begin
        chk(mon_e.nm, {q1, p1, err1}, mon_e.exp);
      end else begin
        n_chk++;
        n_err++;
        $display("FAIL %s: missed due cycle %0d (now %0d)", mon_e.nm, mon_e.due, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic drain_sb(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: %0d scoreboard entries never compared", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int         k;
    logic [2:0] prev;

    tbl[0]  = '{1'b1, 1'b1, 6, mk(0, 1, 0)};
    tbl[1]  = '{1'b0, 1'b1, 5, mk(0, 1, 0)};
    tbl[2]  = '{1'b1, 1'b0, 5, mk(1, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, 5, mk(1, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, 2, mk(1, 1, 1)};
    tbl[5]  = '{1'b0, 1'b1, 4, mk(0, 1, 1)};
    tbl[6]  = '{1'b1, 1'b0, 4, mk(1, 0, 1)};
    tbl[7]  = '{1'b1, 1'b1, 4, mk(1, 0, 1)};
    tbl[8]  = '{1'b0, 1'b0, 3, mk(1, 1, 1)};
    tbl[9]  = '{1'b1, 1'b1, 4, mk(0, 1, 1)};
    tbl[10] = '{1'b1, 1'b0, 4, mk(1, 0, 1)};
    tbl[11] = '{1'b0, 1'b0, 3, mk(1, 1, 1)};
    tbl[12] = '{1'b1, 1'b0, 4, mk(1, 0, 1)};
    tbl[13] = '{1'b1, 1'b1, 4, mk(1, 0, 1)};

    rst = 1'b1;
    r1 = 1'b1; h1 = 1'b1; r2 = 1'b1; h2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dut1", {q1, p1, err1}, mk(0, 1, 0));
    chk("reset_dut2", {q2, p2, err2}, mk(0, 1, 0));
    rst = 1'b0;

    // Filter instance: 2- and 3-sample pulses must be ignored.
    @(negedge clk);
    h2 = 1'b0;
    repeat (2) @(negedge clk);
    h2 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("f4_pulse2_ignored", {q2, p2, err2}, mk(0, 1, 0));
    end
    h2 = 1'b0;
    repeat (3) @(negedge clk);
    h2 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("f4_pulse3_ignored", {q2, p2, err2}, mk(0, 1, 0));
    end
    // Sustained H=0: SET exactly SYNC_STAGES+FILTER_CYCLES = 6 edges later.
    h2 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("f4_hold_edge5_not_yet", {q2, p2, err2}, mk(0, 1, 0));
    @(posedge clk);
    #2;
    chk("f4_hold_edge6_set", {q2, p2, err2}, mk(1, 0, 0));
    @(negedge clk);
    h2 = 1'b1;

    // Table-driven vectors on the default instance.
    prev = mk(0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      r1 = tbl[i].r;
      h1 = tbl[i].h;
      k  = cyc;
      sb.push_back('{due: k + 2, exp: prev, nm: $sformatf("vec%0d_before_latency", i)});
      sb.push_back('{due: k + 3, exp: tbl[i].exp, nm: $sformatf("vec%0d_at_latency", i)});
      sb.push_back('{due: k + tbl[i].hold + 2, exp: tbl[i].exp, nm: $sformatf("vec%0d_held", i)});
      repeat (tbl[i].hold - 1) @(negedge clk);
      prev = tbl[i].exp;
    end
    drain_sb("vec_drain");

    // Async reset while in SET, with H still active through reset.
    @(negedge clk);
    r1 = 1'b1;
    h1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_set", {q1, p1, err1}, mk(1, 0, 1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_clear", {q1, p1, err1}, mk(0, 1, 0));
    @(negedge clk);
    chk("rst_held", {q1, p1, err1}, mk(0, 1, 0));
    rst = 1'b0;
    k = cyc;
    sb.push_back('{due: k + 1, exp: mk(0, 1, 0), nm: "post_rst_edge1"});
    sb.push_back('{due: k + 2, exp: mk(0, 1, 0), nm: "post_rst_edge2"});
    sb.push_back('{due: k + 3, exp: mk(1, 0, 0), nm: "post_rst_edge3_set"});
    drain_sb("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
